sevenseg_scan: RTL and testbench
================================

# sevenseg_scan

Multiplexed multi-digit hex seven-segment driver for the board display of the pipelined computer. Captures a packed vector of `DIGITS` nibbles into a shadow register on a load strobe. Time-multiplexes the shared segment bus across `DIGITS` common-anode digits, with a programmable scan rate and an anti-ghosting guard interval. Replaces the per-digit combinational decoders in the top level, which saves pins when the display is scanned.

## Interface
- `DIGITS`, default 4: number of digits, legal range 1..8.
- `SCAN_DIV`, default 50000: clocks per digit slot, minimum 2.
- `GUARD`, default 500: clocks at the start of each slot with all anodes off; must satisfy 0 ≤ GUARD < SCAN_DIV.
- `clock` in, 1 bit: single clock; all logic is rising-edge.
- `reset` in, 1 bit: synchronous, active-high.
- `data` in, 4*DIGITS bits: nibble i is `data[4i+3:4i]`; digit 0 is least significant.
- `load` in, 1 bit: when high at an edge, the shadow register captures `data`.
- `blank` in, DIGITS bits: bit i high forces digit i segments and dp off.
- `dp` in, DIGITS bits: decimal point request per digit; sampled live, not shadowed.
- `seg_out` out, 7 bits: segments {g,f,e,d,c,b,a}, active-low.
- `dp_out` out, 1 bit: decimal point, active-low.
- `digit_en` out, DIGITS bits: anode enables, active-low, at most one bit low.

## Operation
- **Shadow register.** `shadow <= data` on any edge with `load=1`; otherwise it holds. Display content changes only through `load`, so there is no tearing mid-scan.
- **Slot counter.** `cnt` counts 0..SCAN_DIV-1 and wraps to 0. At `cnt==SCAN_DIV-1`, the digit index `idx` increments and wraps from DIGITS-1 to 0. When DIGITS=1, `idx` stays 0.
- **Guard interval.** While `cnt<GUARD`, the next `digit_en` is all ones, `seg_out` is 7'h7F, and `dp_out` is 1.
- **Decode** of nibble `shadow[idx]`, hex 0..F → 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E. Glyphs are 0-9, A, b, C, d, E, F.
- **Digit blanking.** If `blank[idx]=1`, the digit's anode is still enabled, but `seg_out` is 7'h7F and `dp_out` is 1.
- **Anode enable.** Outside the guard interval, `digit_en` is all ones except bit `idx`, which is 0.
- **Registering.** All outputs are registered. Output values at edge N+1 are computed from `cnt`, `idx`, `shadow`, `blank` and `dp` as they stand after edge N.

## Timing
- **Reset.**
  - State: `cnt=0`, `idx=0`, `shadow=0`.
  - Outputs: `seg_out`=7'h7F, `dp_out`=1, `digit_en` all ones.
  - Effect: reset overrides `load` at the same edge, and reset mid-scan restarts at digit 0, slot cycle 0.
- **Load latency.** Data loaded at edge N appears on `seg_out` at edge N+1 if digit `idx` is being driven.
- **Load and wrap together.** `load` coinciding with slot wrap is legal; the new digit shows the new data one edge later.
- **Period.** A full frame is DIGITS*SCAN_DIV clocks. Each anode is low for SCAN_DIV-GUARD clocks per frame.
- **Guard of zero.** With GUARD=0, anodes switch directly from one digit to the next with no dark cycle.

## Configuration
- **`SEVENSEG_LZS_EN` defined:** leading-zero suppression is compiled in.
  - Digit i > 0 has its segments forced to 7'h7F when nibbles i..DIGITS-1 of `shadow` are all zero.
  - Digit 0 is never suppressed.
  - `dp_out` for a suppressed digit still follows `dp[i]`.
- **`SEVENSEG_LZS_EN` undefined:** all digits always decode, and no suppression logic is present.

## Test plan
Bench configuration: DIGITS=4, SCAN_DIV=4, GUARD=1.
- **Reset state.** Hold `reset` for 3 edges → `seg_out`=7F, `dp_out`=1, `digit_en`=4'hF. After release, the first anode-low output is `digit_en`=4'hE, appearing 2 edges after release.
- **Scan order.** Load 16'h3210, then run 16 clocks → `digit_en` sequence F,E,E,E,F,D,D,D,F,B,B,B,F,7,7,7. `seg_out` is 40, 79, 24, 30 during the respective slots.
- **Hold and reload.** Change `data` without `load` → no display change. Then pulse `load` with 16'hFEDC → digits show 46,21,06,0E on the next frames.
- **Blank and dp.** `blank`=4'b0100, `dp`=4'b0001 → digit 2 has `seg_out`=7F with its anode still low. Digit 0 has `dp_out`=0; all other digits have `dp_out`=1.
- **Leading-zero suppression.** With `SEVENSEG_LZS_EN`, load 16'h0050 → digits 3 and 2 have `seg_out`=7F, digit 1=12, digit 0=40. Loading 16'h0000 shows only digit 0=40. Without the macro, the same 16'h0050 load shows 40,40,12,40.
- **Reset mid-scan.** Assert `reset` at digit 2, cnt=2 → next edge gives all outputs off and `shadow=0`. After release, the scan resumes from digit 0.

Source files
------------

// File: rtl/sevenseg_scan.sv
// Multiplexed hex seven-segment driver: shadowed digits, scanned anodes, guard interval.
// Optional leading-zero suppression is compiled in with `define SEVENSEG_LZS_EN.
module sevenseg_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000,
  parameter int GUARD    = 500
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  load,
  input  logic [DIGITS-1:0]     blank,
  input  logic [DIGITS-1:0]     dp,
  output logic [6:0]            seg_out,
  output logic                  dp_out,
  output logic [DIGITS-1:0]     digit_en
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] GUARD_C  = CW'(GUARD);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  logic [DIGITS-1:0][3:0] shadow;
  logic [CW-1:0]          cnt;
  logic [IW-1:0]          idx;

  logic [6:0]        seg_nxt;
  logic              dp_nxt;
  logic [DIGITS-1:0] en_nxt;
  logic              in_guard;
  logic              suppress;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40; 4'h1: hex7 = 7'h79; 4'h2: hex7 = 7'h24; 4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19; 4'h5: hex7 = 7'h12; 4'h6: hex7 = 7'h02; 4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00; 4'h9: hex7 = 7'h10; 4'hA: hex7 = 7'h08; 4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46; 4'hD: hex7 = 7'h21; 4'hE: hex7 = 7'h06; default: hex7 = 7'h0E;
    endcase
  endfunction

`ifdef SEVENSEG_LZS_EN
  // lz[i]: nibbles i..DIGITS-1 of the shadow are all zero
  logic [DIGITS-1:0] lz;
  assign lz[DIGITS-1] = (shadow[DIGITS-1] == 4'h0);
  for (genvar i = 0; i < DIGITS - 1; i++) begin : g_lz
    assign lz[i] = lz[i+1] && (shadow[i] == 4'h0);
  end
  assign suppress = (idx != '0) && lz[idx];
`else
  assign suppress = 1'b0;
`endif

  assign in_guard = (GUARD > 0) && (cnt < GUARD_C);

  always_comb begin
    seg_nxt = 7'h7F;
    dp_nxt  = 1'b1;
    en_nxt  = '1;
    if (!in_guard) begin
      en_nxt[idx] = 1'b0;
      if (!blank[idx]) begin
        dp_nxt  = ~dp[idx];
        seg_nxt = suppress ? 7'h7F : hex7(shadow[idx]);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      shadow   <= '0;
      cnt      <= '0;
      idx      <= '0;
      seg_out  <= 7'h7F;
      dp_out   <= 1'b1;
      digit_en <= '1;
    end else begin
      if (load) shadow <= data;
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
      seg_out  <= seg_nxt;
      dp_out   <= dp_nxt;
      digit_en <= en_nxt;
    end
  end

endmodule

// File: tb/tb_sevenseg_scan.sv
// Scoreboard bench for sevenseg_scan: driver pushes model predictions, monitor pops and compares.
module tb_sevenseg_scan;
  localparam int D = 4, SD = 4, G = 1;

  logic clock = 1'b0, reset = 1'b1, load = 1'b0;
  logic [15:0] data = '0;
  logic [3:0]  blank = '0, dp = '0;
  logic [6:0]  seg_out;
  logic        dp_out;
  logic [3:0]  digit_en;

  sevenseg_scan #(.DIGITS(D), .SCAN_DIV(SD), .GUARD(G)) dut (
    .clock(clock), .reset(reset), .data(data), .load(load), .blank(blank), .dp(dp),
    .seg_out(seg_out), .dp_out(dp_out), .digit_en(digit_en));

  always #5 clock = ~clock;

  typedef struct packed { logic [6:0] seg; logic dp; logic [3:0] en; } exp_t;
  exp_t q[$];
  int n_chk = 0, n_fail = 0;

  logic [6:0] tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // model state: edges since reset release, and the displayed word
  int k = 0;
  logic [15:0] m_sh = '0;

  function automatic exp_t predict(int kk, logic [15:0] sh, logic [3:0] bl, logic [3:0] d);
    exp_t e;
    int c, id;
    logic [3:0] nib;
    logic sup;
    e = '{seg: 7'h7F, dp: 1'b1, en: 4'hF};
    c  = (kk - 1) % SD;
    id = ((kk - 1) / SD) % D;
    if (c < G) return e;
    e.en = ~(4'b1 << id);
    if (bl[id]) return e;
    nib = 4'((sh >> (4 * id)) & 16'hF);
`ifdef SEVENSEG_LZS_EN
    sup = (id > 0) && ((sh >> (4 * id)) == 16'h0);
`else
    sup = 1'b0;
`endif
    e.dp  = ~d[id];
    e.seg = sup ? 7'h7F : tbl[nib];
    return e;
  endfunction

  task automatic cyc(input logic rst, input logic ld, input logic [15:0] dat,
                     input logic [3:0] bl, input logic [3:0] d);
    @(negedge clock);
    reset = rst; load = ld; data = dat; blank = bl; dp = d;
    if (rst) begin
      q.push_back('{seg: 7'h7F, dp: 1'b1, en: 4'hF});
      k = 0;
      m_sh = '0;
    end else begin
      k++;
      q.push_back(predict(k, m_sh, bl, d));
      if (ld) m_sh = dat;
    end
  endtask

  task automatic run(input int n, input logic [3:0] bl, input logic [3:0] d);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h9999, bl, d);
  endtask

  // monitor
  initial begin
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        n_chk++;
        if (seg_out !== e.seg || dp_out !== e.dp || digit_en !== e.en) begin
          n_fail++;
          $display("FAIL outputs @%0t: got seg=%h dp=%b en=%h, expected seg=%h dp=%b en=%h",
                   $time, seg_out, dp_out, digit_en, e.seg, e.dp, e.en);
        end
      end
    end
  end

  initial begin
    int waits;
    // reset held 3 edges, with a load that must be ignored
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b1, 16'hABCD, 4'h0, 4'h0);
    // scan order
    cyc(1'b0, 1'b1, 16'h3210, 4'h0, 4'h0);
    run(19, 4'h0, 4'h0);
    // hold without load, then reload
    run(16, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 16'hFEDC, 4'h0, 4'h0);
    run(20, 4'h0, 4'h0);
    // blank and dp
    run(16, 4'b0100, 4'b0001);
    // leading zeros
    cyc(1'b0, 1'b1, 16'h0050, 4'h0, 4'h0);
    run(17, 4'h0, 4'b1010);
    cyc(1'b0, 1'b1, 16'h0000, 4'h0, 4'h0);
    run(17, 4'h0, 4'h0);
    // reset mid-scan at digit 2, cnt 2
    cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 16'h7A5C, 4'h0, 4'h0);
    run(9, 4'h0, 4'h0);
    cyc(1'b1, 1'b0, 16'h0, 4'h0, 4'h0);
    run(20, 4'h0, 4'h0);
    cyc(1'b0, 1'b1, 16'h1234, 4'h0, 4'h0);
    run(16, 4'h0, 4'h0);
    // random traffic, including loads on slot wraps
    for (int i = 0; i < 600; i++)
      cyc(($urandom_range(0, 79) == 0), ($urandom_range(0, 5) == 0), 16'($urandom),
          ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0, 4'($urandom));
    waits = 0;
    while (q.size() > 0 && waits < 10) begin
      @(posedge clock);
      waits++;
    end
    @(negedge clock);
    if (q.size() > 0) begin
      n_fail++;
      $display("FAIL drain: %0d expected outputs never compared, expected 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
